// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the game sequencer.
// Mode encoding and key-vector bit positions.
package game_pkg;

    typedef enum logic [2:0] {
        GS_TITLE   = 3'd0,
        GS_PLAYING = 3'd1,
        GS_PAUSED  = 3'd2,
        GS_OVER    = 3'd3,
        GS_RESTART = 3'd4
    } game_state_e;

    localparam int KEY_W = 8;

    // Key vector layout: {Esc, Enter, S, R, D, A, W, space}
    localparam int K_SPACE = 0;
    localparam int K_W     = 1;
    localparam int K_A     = 2;
    localparam int K_D     = 3;
    localparam int K_R     = 4;
    localparam int K_S     = 5;
    localparam int K_ENTER = 6;
    localparam int K_ESC   = 7;

endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect: rising-edge detector for the key flag vector.
// History resets to all ones so keys held through reset stay quiet.
module key_edge_detect
    import game_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] keys,
    output logic [KEY_W-1:0] evt
);

    logic [KEY_W-1:0] keys_q;
    logic [KEY_W-1:0] keys_d;

    // Next history is simply the current key levels.
    always_comb begin
        keys_d = keys;
    end

    // History register, preset to ones on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            keys_q <= '1;
        end else begin
            keys_q <= keys_d;
        end
    end

    assign evt = keys & ~keys_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game-mode FSM, restart countdown, jump latch
// and frame-aligned player action strobes.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned RESTART_FRAMES = 60
) (
    input  logic       Clock_50,
    input  logic       Reset_h,
    input  logic       frame_pulse,
    input  logic       space,
    input  logic       W,
    input  logic       A,
    input  logic       D,
    input  logic       R,
    input  logic       S,
    input  logic       Enter,
    input  logic       Esc,
    input  logic       player_dead,
    output logic [2:0] game_state,
    output logic       game_reset,
    output logic [7:0] countdown,
    output logic       freeze,
    output logic       jump,
    output logic       move_left,
    output logic       move_right,
    output logic       crouch
);

    localparam logic [7:0] RESTART_CNT = 8'(RESTART_FRAMES);

    logic [KEY_W-1:0] keys;
    logic [KEY_W-1:0] evt;

    game_state_e state_q, state_d;
    logic [7:0]  cd_q, cd_d;
    logic        gres_q, gres_d;
    logic        frz_q, frz_d;
    logic        pend_q, pend_d;
    logic        jump_q, jump_d;
    logic        ml_q, ml_d;
    logic        mr_q, mr_d;
    logic        cr_q, cr_d;
    logic        jump_evt;
    logic        frame_act;

    assign keys = {Esc, Enter, S, R, D, A, W, space};

    key_edge_detect u_edge (
        .clk  (Clock_50),
        .rst  (Reset_h),
        .keys (keys),
        .evt  (evt)
    );

    assign jump_evt  = evt[K_SPACE] | evt[K_W];
    assign frame_act = frame_pulse & (state_q == GS_PLAYING);

    // Mode transitions and restart countdown.
    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        unique case (state_q)
            GS_TITLE: begin
                if (evt[K_ENTER]) state_d = GS_RESTART;
            end
            GS_RESTART: begin
                if (frame_pulse) begin
                    if (cd_q <= 8'd1) begin
                        state_d = GS_PLAYING;
                        cd_d    = 8'd0;
                    end else begin
                        cd_d = cd_q - 8'd1;
                    end
                end
            end
            GS_PLAYING: begin
                if (player_dead)     state_d = GS_OVER;
                else if (evt[K_R])   state_d = GS_RESTART;
                else if (evt[K_ESC]) state_d = GS_PAUSED;
            end
            GS_PAUSED: begin
                if (evt[K_R])
                    state_d = GS_RESTART;
                else if (evt[K_ESC] | evt[K_ENTER])
                    state_d = GS_PLAYING;
            end
            GS_OVER: begin
                if (evt[K_ENTER] | evt[K_R])
                    state_d = GS_RESTART;
                else if (evt[K_ESC])
                    state_d = GS_TITLE;
            end
            default: begin
                state_d = GS_TITLE;
                cd_d    = 8'd0;
            end
        endcase
        if (state_d == GS_RESTART && state_q != GS_RESTART)
            cd_d = RESTART_CNT;
    end

    // Mode-derived levels, jump latch and frame strobes.
    always_comb begin
        gres_d = (state_d == GS_RESTART);
        frz_d  = (state_d != GS_PLAYING);
        cr_d   = S & (state_d == GS_PLAYING);
        jump_d = 1'b0;
        ml_d   = 1'b0;
        mr_d   = 1'b0;
        pend_d = pend_q;
        if (frame_act) begin
            jump_d = pend_q | jump_evt;
            ml_d   = A & ~D;
            mr_d   = D & ~A;
        end
        if (state_q != GS_PLAYING || state_d != GS_PLAYING)
            pend_d = 1'b0;
        else if (frame_pulse)
            pend_d = 1'b0;
        else if (jump_evt)
            pend_d = 1'b1;
    end

    // Registered state and outputs.
    always_ff @(posedge Clock_50) begin
        if (Reset_h) begin
            state_q <= GS_TITLE;
            cd_q    <= 8'd0;
            gres_q  <= 1'b0;
            frz_q   <= 1'b1;
            pend_q  <= 1'b0;
            jump_q  <= 1'b0;
            ml_q    <= 1'b0;
            mr_q    <= 1'b0;
            cr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            gres_q  <= gres_d;
            frz_q   <= frz_d;
            pend_q  <= pend_d;
            jump_q  <= jump_d;
            ml_q    <= ml_d;
            mr_q    <= mr_d;
            cr_q    <= cr_d;
        end
    end

    assign game_state = state_q;
    assign countdown  = cd_q;
    assign game_reset = gres_q;
    assign freeze     = frz_q;
    assign jump       = jump_q;
    assign move_left  = ml_q;
    assign move_right = mr_q;
    assign crouch     = cr_q;

endmodule
